// File: rtl/mux_rr_pkg.sv
// Shared types for the registered round-robin / fixed-select multiplexer.
package mux_rr_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_t;

endpackage

// File: rtl/mux_rr_if.sv
// Handshake bundle between M producers, the mux, and one consumer.
interface mux_rr_if
    import mux_rr_pkg::*;
#(
    parameter int unsigned N = 64,
    parameter int unsigned M = 4
);
    localparam int unsigned SW = $clog2(M);

    mode_t                 i_mode;
    logic [SW-1:0]         i_s;
    logic [M-1:0][N-1:0]   i_data;
    logic [M-1:0]          i_valid;
    logic [M-1:0]          o_ready;
    logic [N-1:0]          o_data;
    logic                  o_valid;
    logic [SW-1:0]         o_sel;
    logic                  i_ready;

    // Mux side
    modport slave (
        input  i_mode, i_s, i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid, o_sel
    );

    // Producer/consumer side
    modport master (
        output i_mode, i_s, i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid, o_sel
    );

endinterface

// File: rtl/mux_rr_rr_pick.sv
// Combinational round-robin picker: first set request after the pointer,
// wrapping modulo M (not modulo 2**SW).
module rr_pick #(
    parameter  int unsigned M  = 4,
    localparam int unsigned SW = $clog2(M)
) (
    input  logic [M-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic          found_o,
    output logic [SW-1:0] idx_o
);

    logic [SW-1:0] pos;

    // Scan ptr+1 .. ptr+M; earliest hit in scan order wins
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int unsigned k = 1; k <= M; k++) begin
            pos = SW'((32'(ptr_i) + k) % M);
            if (!found_o && req_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/mux_rr.sv
// M-channel, N-bit multiplexer with registered output, valid/ready on every
// channel, and fixed-select or round-robin channel choice.
module mux_rr
    import mux_rr_pkg::*;
#(
    parameter int unsigned N = 64,
    parameter int unsigned M = 4
) (
    input logic      i_clk,
    input logic      i_rst,
    mux_rr_if.slave  bus
);

    localparam int unsigned SW = $clog2(M);
    localparam int unsigned SP = 1 << SW;

    logic [N-1:0]  data_q,  data_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] sel_q,   sel_d;
    logic [SW-1:0] ptr_q,   ptr_d;

    logic          load;
    logic [SP-1:0] valid_pad;
    logic          fix_ok;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic          cand_found;
    logic [SW-1:0] cand_idx;
    logic          grant;

    // Padding i_valid to 2**SW lets an out-of-range i_s read a harmless 0
    assign valid_pad = SP'(bus.i_valid);
    assign fix_ok    = (32'(bus.i_s) < M) && valid_pad[bus.i_s];
    assign load      = !valid_q || bus.i_ready;

    rr_pick #(.M(M)) u_pick (
        .req_i   (bus.i_valid),
        .ptr_i   (ptr_q),
        .found_o (rr_found),
        .idx_o   (rr_idx)
    );

    // Candidate channel according to the selection mode
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        if (bus.i_mode == MODE_RR) begin
            cand_found = rr_found;
            cand_idx   = rr_idx;
        end else if (fix_ok) begin
            cand_found = 1'b1;
            cand_idx   = bus.i_s;
        end
    end

    assign grant       = load && cand_found && !i_rst;
    assign bus.o_ready = grant ? (M'(1) << cand_idx) : '0;

    // Next state of output register and round-robin pointer
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (grant) begin
                data_d  = bus.i_data[cand_idx];
                sel_d   = cand_idx;
                valid_d = 1'b1;
                if (bus.i_mode == MODE_RR) begin
                    ptr_d = cand_idx;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers; pointer resets to M-1 so the first scan starts at 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= SW'(M - 1);
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_sel   = sel_q;

endmodule

// File: tb/tb_mux_rr.sv
// Scoreboard bench for mux_rr: stimulus predicts grants and queues expected
// output words; an independent monitor pops them on each output transfer.
module tb_mux_rr;
    import mux_rr_pkg::*;

    localparam int unsigned N = 64;
    localparam int unsigned M = 4;

    typedef struct packed {
        logic [N-1:0] data;
        logic [1:0]   sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_rr_if #(.N(N), .M(M)) bus ();
    mux_rr_if #(.N(N), .M(3)) bus3 ();

    mux_rr #(.N(N), .M(M)) dut  (.i_clk(clk), .i_rst(rst), .bus(bus));
    mux_rr #(.N(N), .M(3)) dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic m_valid  = 1'b0;
    int   m_ptr    = M - 1;

    logic [M-1:0][N-1:0] dflt;
    logic [M-1:0][N-1:0] r_d;
    logic                r_mode;
    logic [1:0]          r_s;
    logic [M-1:0]        r_v;
    logic                r_rdy;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference choice: fixed index if valid, else first valid after ptr mod M
    function automatic int model_pick(input logic mode, input int s, input logic [M-1:0] v, input int ptr);
        if (mode == 1'b0) begin
            if (s < M && v[s]) return s;
            return -1;
        end
        for (int k = 1; k <= M; k++) begin
            int c;
            c = (ptr + k) % M;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock of stimulus; entered and left at posedge+1
    task automatic cycle(input logic mode, input logic [1:0] s, input logic [M-1:0] v,
                         input logic rdy, input logic [M-1:0][N-1:0] d);
        int           c;
        logic         load;
        logic [M-1:0] exp_rdy;
        bus.i_mode  = mode_t'(mode);
        bus.i_s     = s;
        bus.i_valid = v;
        bus.i_ready = rdy;
        bus.i_data  = d;
        #1;
        check("o_valid", 64'(bus.o_valid), 64'(m_valid));
        load    = !m_valid || rdy;
        c       = load ? model_pick(mode, int'(s), v, m_ptr) : -1;
        exp_rdy = '0;
        if (c >= 0) exp_rdy[c] = 1'b1;
        check("o_ready", 64'(bus.o_ready), 64'(exp_rdy));
        if (c >= 0) begin
            sb.push_back('{data: d[c], sel: 2'(c)});
            m_valid = 1'b1;
            if (mode) m_ptr = c;
        end else if (load) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each output transfer, checks stability while stalled
    initial begin : monitor
        exp_t         e;
        logic         hold_chk;
        logic [N-1:0] hold_data;
        logic [1:0]   hold_sel;
        hold_chk  = 1'b0;
        hold_data = '0;
        hold_sel  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    check("hold_data", bus.o_data, hold_data);
                    check("hold_sel", 64'(bus.o_sel), 64'(hold_sel));
                end
                hold_chk = 1'b0;
                if (bus.o_valid && bus.i_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL out_unexpected: got data 0x%0h sel %0d, expected no output at %0t",
                                 bus.o_data, bus.o_sel, $time);
                    end else begin
                        e = sb.pop_front();
                        check("o_data", bus.o_data, e.data);
                        check("o_sel", 64'(bus.o_sel), 64'(e.sel));
                    end
                end else if (bus.o_valid) begin
                    hold_chk  = 1'b1;
                    hold_data = bus.o_data;
                    hold_sel  = bus.o_sel;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1);
    end

    initial begin : stim
        dflt = {64'd4, 64'd3, 64'd2, 64'd1};
        bus.i_mode   = MODE_FIXED;
        bus.i_s      = '0;
        bus.i_data   = dflt;
        bus.i_valid  = '0;
        bus.i_ready  = 1'b1;
        bus3.i_mode  = MODE_FIXED;
        bus3.i_s     = '0;
        bus3.i_valid = '0;
        bus3.i_ready = 1'b1;
        for (int unsigned c = 0; c < 3; c++) bus3.i_data[c] = 64'(c + 10);

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        check("rst_o_valid", 64'(bus.o_valid), 64'd0);
        check("rst_o_data", bus.o_data, 64'd0);
        check("rst_o_sel", 64'(bus.o_sel), 64'd0);
        check("rst_o_ready", 64'(bus.o_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // M=3 instance: i_s=3 never granted, then RR wraps modulo 3
        bus3.i_s     = 2'd3;
        bus3.i_valid = 3'b111;
        repeat (3) begin
            #1 check("m3_ready_s3", 64'(bus3.o_ready), 64'd0);
            @(posedge clk);
            #1 check("m3_valid_s3", 64'(bus3.o_valid), 64'd0);
        end
        bus3.i_s = 2'd2;
        #1 check("m3_ready_s2", 64'(bus3.o_ready), 64'(3'b100));
        @(posedge clk);
        #1;
        check("m3_valid_s2", 64'(bus3.o_valid), 64'd1);
        check("m3_data_s2", bus3.o_data, 64'd12);
        check("m3_sel_s2", 64'(bus3.o_sel), 64'd2);
        bus3.i_mode = MODE_RR;
        for (int unsigned k = 0; k < 4; k++) begin
            int unsigned ex;
            ex = k % 3;
            #1 check("m3_rr_ready", 64'(bus3.o_ready), 64'(1 << ex));
            @(posedge clk);
            #1;
            check("m3_rr_data", bus3.o_data, 64'(ex + 10));
            check("m3_rr_sel", 64'(bus3.o_sel), 64'(ex));
        end
        bus3.i_valid = '0;

        // Fixed select on each channel
        cycle(1'b0, 2'd2, 4'b1111, 1'b1, dflt);
        cycle(1'b0, 2'd0, 4'b1111, 1'b1, dflt);
        cycle(1'b0, 2'd1, 4'b1111, 1'b1, dflt);
        cycle(1'b0, 2'd3, 4'b1111, 1'b1, dflt);

        // Round-robin full load, then sparse with wrap
        repeat (8) cycle(1'b1, 2'd0, 4'b1111, 1'b1, dflt);
        repeat (4) cycle(1'b1, 2'd0, 4'b1010, 1'b1, dflt);

        // Backpressure: first load, stall 5 cycles, release
        cycle(1'b0, 2'd0, 4'b0000, 1'b1, dflt);
        cycle(1'b0, 2'd0, 4'b0000, 1'b1, dflt);
        cycle(1'b1, 2'd0, 4'b1111, 1'b1, dflt);
        repeat (5) cycle(1'b1, 2'd0, 4'b1111, 1'b0, dflt);
        repeat (2) cycle(1'b1, 2'd0, 4'b1111, 1'b1, dflt);

        // Fixed select on an invalid channel, then it becomes valid
        cycle(1'b0, 2'd3, 4'b0111, 1'b1, dflt);
        repeat (2) cycle(1'b0, 2'd3, 4'b0111, 1'b1, dflt);
        cycle(1'b0, 2'd3, 4'b1111, 1'b1, dflt);

        // Mode/select change while stalled does not disturb held word
        cycle(1'b1, 2'd0, 4'b1111, 1'b0, dflt);
        cycle(1'b0, 2'd1, 4'b1111, 1'b0, dflt);
        cycle(1'b0, 2'd1, 4'b1111, 1'b1, dflt);

        // Reset mid-operation with a held word
        cycle(1'b1, 2'd0, 4'b1111, 1'b1, dflt);
        bus.i_mode  = MODE_RR;
        bus.i_valid = 4'b1111;
        bus.i_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_o_valid", 64'(bus.o_valid), 64'd0);
        check("mid_rst_o_data", bus.o_data, 64'd0);
        check("mid_rst_o_sel", 64'(bus.o_sel), 64'd0);
        check("mid_rst_o_ready", 64'(bus.o_ready), 64'd0);
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = M - 1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) cycle(1'b1, 2'd0, 4'b1111, 1'b1, dflt);

        // Randomised traffic
        repeat (400) begin
            for (int unsigned c = 0; c < M; c++) r_d[c] = {$urandom, $urandom};
            r_mode = 1'($urandom_range(0, 1));
            r_s    = 2'($urandom_range(0, 3));
            r_v    = 4'($urandom_range(0, 15));
            r_rdy  = ($urandom_range(0, 3) != 0);
            cycle(r_mode, r_s, r_v, r_rdy, r_d);
        end

        // Drain
        repeat (3) cycle(1'b0, 2'd0, 4'b0000, 1'b1, dflt);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr.md
Name: mux_rr

Overview:
- Parametrised M-channel, N-bit multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Two selection modes: fixed select via i_s, or round-robin arbitration among valid channels.
- Successor to the combinational 4:1 mux; used wherever several producers share one consumer datapath.

Parameters:
- N, 64, data width per channel in bits.
- M, 4, number of input channels (M >= 2; need not be a power of two).
- SW, $clog2(M), select/index width (derived, not overridden).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_mode  input  1  0 = MODE_FIXED (use i_s), 1 = MODE_RR (round-robin).
- i_s  input  SW  channel select in MODE_FIXED; ignored in MODE_RR.
- i_data  input  M x N  packed array, channel c = i_data[c].
- i_valid  input  M  per-channel valid.
- o_ready  output  M  per-channel grant/ready; at most one bit set; combinational.
- o_data  output  N  registered output data.
- o_valid  output  1  registered output valid.
- o_sel  output  SW  index of the channel held in o_data.
- i_ready  input  1  downstream ready.

Behaviour:
- Reset (async, immediate on i_rst=1): o_valid=0, o_data=0, o_sel=0, RR pointer p=M-1, so the first search starts at channel 0. o_ready=0 while i_rst=1.
- Load enable: load = !o_valid || i_ready. Output transfer occurs when o_valid && i_ready.
- Candidate channel c, combinational:
  - MODE_FIXED: c=i_s, but only if i_s < M and i_valid[i_s]=1; otherwise no candidate.
  - MODE_RR: first index with i_valid set, scanning p+1, p+2, ... and wrapping modulo M (not modulo 2^SW). No candidate if i_valid=0.
- Grant: o_ready[c]=1 if and only if load=1 and a candidate exists; all other bits are 0. The input transfer is i_valid[c] && o_ready[c].
- On an input transfer at a clock edge: o_data<=i_data[c], o_sel<=c, o_valid<=1. In MODE_RR only, p<=c. MODE_FIXED never moves p.
- If load=1 and there is no candidate: o_valid<=0; o_data and o_sel hold their last value.
- If load=0 (o_valid=1, i_ready=0): all outputs hold and o_ready=0.
- Latency: 1 cycle from input transfer to o_valid.
- Throughput: 1 transfer/cycle. A downstream accept and a new load in the same cycle give back-to-back output with no bubble.
- o_data is stable while o_valid && !i_ready.
- A change of i_mode or i_s while o_valid is held does not affect the held output; it takes effect at the next load decision.
- Reset during operation discards the held word; no transfer is reported in that cycle.
- Fairness: in MODE_RR with all channels continuously valid, each channel is granted exactly once per M grants.

Decomposition:
- Package mux_rr_pkg:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mode_t.
  - No width constants; widths come from the module parameters.
- Sub-module rr_pick #(M):
  - Purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: found flag, index of first request after the pointer (with wrap).
  - Reused by future arbiters.
- mux_rr holds the output register, the pointer register, mode selection and grant generation.

Test Plan (N=64, M=4, i_data = {4,3,2,1} for channels 3..0 unless stated):
- Reset: drive i_rst=1 mid-cycle while o_valid=1 -> o_valid=0, o_data=0, o_sel=0 before the next edge; o_ready=0000.
- Fixed select: i_mode=0, i_s=2, i_valid=1111, i_ready=1 -> o_ready=0100; after 1 edge o_data=3, o_valid=1, o_sel=2. Repeat for i_s=0,1,3 -> o_data 1, 2, 4.
- RR full load: i_mode=1, i_valid=1111, i_ready=1 held -> o_data on consecutive edges 1,2,3,4,1, o_sel 0,1,2,3,0, with no bubbles.
- RR sparse with wrap: i_valid=1010 -> o_data 2,4,2,4; o_ready alternates 0010/1000.
- Backpressure: RR, all valid, i_ready=0 after the first load -> o_data holds 1, o_ready=0000, pointer frozen for 5 cycles; then i_ready=1 -> next o_data=2.
- Fixed select, invalid channel: i_mode=0, i_s=3, i_valid=0111 -> o_ready=0000, o_valid stays 0; set i_valid[3]=1 -> o_data=4 after 1 edge. With M=3, i_s=3 -> never granted.
